downscale_stream_out: RTL and testbench
=======================================

DOWNSCALE_STREAM_OUT -- requirements
Module: downscale_stream_out

Interface
REQ-001 The block SHALL have parameter DST_H, default 3, meaning rows of the downscaled frame (>=1).
REQ-002 The block SHALL have parameter DST_W, default 3, meaning columns of the downscaled frame (>=1).
REQ-003 The block SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port frame_done  input  1  downscaler done level, held high until its start drops.
REQ-006 The block SHALL have port image_in  input  8 x [DST_H][DST_W]  downscaled frame, valid while frame_done is high.
REQ-007 The block SHALL have port m_valid  output  1  stream pixel valid.
REQ-008 The block SHALL have port m_ready  input  1  stream sink ready.
REQ-009 The block SHALL have port m_data  output  8  pixel value.
REQ-010 The block SHALL have port m_eol  output  1  current pixel is last of its row.
REQ-011 The block SHALL have port m_last  output  1  current pixel is last of the frame.
REQ-012 The block SHALL have port busy  output  1  frame held or streaming.
REQ-013 The block SHALL have port sent  output  1  one-cycle pulse after the final pixel handshake.
REQ-014 The block SHALL have port overrun  output  1  one-cycle pulse when a new frame is dropped.

Function
REQ-015 The block SHALL register frame_done each cycle and detect its rising edge (frame_done=1, previous sample=0).
REQ-016 The block SHALL implement states S_IDLE and S_STREAM.
REQ-017 In S_IDLE on a rising edge, the block SHALL copy all image_in pixels into an internal DST_H x DST_W buffer, clear row/col counters, and enter S_STREAM.
REQ-018 m_valid SHALL be high exactly while in S_STREAM; first m_valid the cycle after the edge is sampled (latency 1).
REQ-019 m_data SHALL equal buffer[row][col]; m_eol SHALL be 1 iff col==DST_W-1; m_last SHALL be 1 iff row==DST_H-1 and col==DST_W-1; all three SHALL be 0 outside S_STREAM.
REQ-020 A handshake SHALL occur when m_valid and m_ready are both 1; only then SHALL the counters advance.
REQ-021 Advance order SHALL be raster: col+1; at col==DST_W-1, col wraps to 0 and row+1.
REQ-022 While m_valid=1 and m_ready=0, m_data, m_eol and m_last SHALL hold stable.
REQ-023 No combinational path SHALL exist from m_ready to m_valid, m_data, m_eol or m_last.
REQ-024 On the handshake with m_last=1, the block SHALL pulse sent for one cycle (the next cycle) and return to S_IDLE, unless REQ-025 applies.
REQ-025 A rising edge coincident with the final handshake SHALL be accepted: buffer recaptured, counters cleared, state stays S_STREAM, sent still pulses, no idle gap.
REQ-026 A rising edge during S_STREAM not on the final handshake SHALL be ignored (buffer unchanged) and pulse overrun for one cycle.
REQ-027 Changes of image_in outside a capture cycle SHALL not affect streamed data.
REQ-028 busy SHALL be 1 in S_STREAM, 0 in S_IDLE.
REQ-029 frame_done held high for many cycles SHALL produce only one capture.
REQ-030 Counters SHALL be sized $clog2 of DST_H/DST_W (minimum 1 bit) and never exceed DST_H-1/DST_W-1; DST_H=DST_W=1 SHALL stream a single pixel with m_eol=m_last=1.

Reset
REQ-031 With rst high at a clock edge, the block SHALL enter S_IDLE, clear counters and the frame_done sample register, and drive m_valid, m_data, m_eol, m_last, busy, sent, overrun to 0.
REQ-032 Reset mid-stream SHALL abandon the frame; no sent pulse SHALL follow; buffer contents need not be cleared.
REQ-033 frame_done high at reset release SHALL not be treated as a rising edge (sample register reloads from 0 only after reset, so an edge is seen only if frame_done was 0 the previous non-reset cycle).

Verification
REQ-034 3x3, image_in = 10..90 row-major, frame_done 0->1, m_ready=1 -> m_valid next cycle, m_data 10,20,...,90 on 9 consecutive cycles, m_eol on 30/60/90, m_last on 90, sent pulse after.
REQ-035 Same frame, m_ready toggled 1,0,0,1,... -> identical data sequence, values held stable across stalled cycles, no duplicates or skips.
REQ-036 Rising edge of frame_done at pixel 4 of streaming -> overrun pulses once, remaining pixels are original frame, sent pulses once.
REQ-037 Second frame (100..180) edge coincident with final handshake of first -> sent pulses, m_valid stays high, next m_data=100, full second frame follows.
REQ-038 rst asserted after 5 handshakes -> next cycle all outputs 0, state idle; new edge after release streams from pixel [0][0].
REQ-039 frame_done held high 50 cycles, image_in changed after capture -> exactly one frame streamed with captured values.

Source files
------------

// File: rtl/downscale_stream_out.sv
// Captures a finished downscaled frame on the rising edge of frame_done and
// streams it out in raster order over a valid/ready handshake.
module downscale_stream_out #(
  parameter int DST_H = 3,
  parameter int DST_W = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               frame_done,
  input  logic [DST_H-1:0][DST_W-1:0][7:0]   image_in,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [7:0]                         m_data,
  output logic                               m_eol,
  output logic                               m_last,
  output logic                               busy,
  output logic                               sent,
  output logic                               overrun
);

  localparam int RW = (DST_H > 1) ? $clog2(DST_H) : 1;
  localparam int CW = (DST_W > 1) ? $clog2(DST_W) : 1;
  localparam logic [RW-1:0] ROW_MAX = RW'(DST_H - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(DST_W - 1);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t                            state_q;
  logic [RW-1:0]                     row_q;
  logic [CW-1:0]                     col_q;
  logic                              fd_q;
  logic                              armed_q;
  logic                              sent_q;
  logic                              overrun_q;
  logic [DST_H-1:0][DST_W-1:0][7:0]  frame_q;

  logic streaming, at_eol, at_last, hs, final_hs, rise, capture;

  assign streaming = (state_q == S_STREAM);
  assign at_eol    = (col_q == COL_MAX);
  assign at_last   = at_eol && (row_q == ROW_MAX);
  assign hs        = streaming && m_ready;
  assign final_hs  = hs && at_last;
  // armed_q masks the first cycle after reset so a level already high at
  // release is not mistaken for a fresh edge.
  assign rise      = frame_done && !fd_q && armed_q;
  assign capture   = rise && (!streaming || final_hs);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      fd_q      <= 1'b0;
      armed_q   <= 1'b0;
      sent_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      fd_q      <= frame_done;
      armed_q   <= 1'b1;
      sent_q    <= final_hs;
      overrun_q <= rise && streaming && !final_hs;
      if (capture) begin
        state_q <= S_STREAM;
        row_q   <= '0;
        col_q   <= '0;
      end else if (hs) begin
        if (at_last) begin
          state_q <= S_IDLE;
          row_q   <= '0;
          col_q   <= '0;
        end else if (at_eol) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && capture) begin
      frame_q <= image_in;
    end
  end

  always_comb begin
    m_data = '0;
    if (streaming) begin
      m_data = frame_q[row_q][col_q];
    end
  end

  assign m_valid = streaming;
  assign busy    = streaming;
  assign m_eol   = streaming && at_eol;
  assign m_last  = streaming && at_last;
  assign sent    = sent_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_downscale_stream_out.sv
// Directed bench for downscale_stream_out at the default 3x3 geometry.
module tb_downscale_stream_out;

  localparam int H = 3;
  localparam int W = 3;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      frame_done;
  logic [H-1:0][W-1:0][7:0]  image_in;
  logic                      m_valid;
  logic                      m_ready;
  logic [7:0]                m_data;
  logic                      m_eol;
  logic                      m_last;
  logic                      busy;
  logic                      sent;
  logic                      overrun;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] got_q[$];
  logic       eol_q[$];
  logic       last_q[$];
  int         sent_cnt = 0;
  int         ovr_cnt  = 0;

  downscale_stream_out #(.DST_H(H), .DST_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_done (frame_done),
    .image_in   (image_in),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_eol      (m_eol),
    .m_last     (m_last),
    .busy       (busy),
    .sent       (sent),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_image(input int base, input int stp);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        image_in[r][c] = 8'(base + stp * (r * W + c));
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    check({tag, "_timeout"}, busy, 0);
    step();
  endtask

  task automatic check_frame(input string tag, input int base, input int off);
    for (int i = 0; i < H * W; i++) begin
      check($sformatf("%s_px%0d", tag, i), got_q[off + i], base + 10 * i);
      check($sformatf("%s_eol%0d", tag, i), eol_q[off + i], (i % W) == W - 1);
      check($sformatf("%s_last%0d", tag, i), last_q[off + i], i == H * W - 1);
    end
  endtask

  // Negedge monitor: inputs change just after posedge, so values seen here
  // are exactly what the next posedge will sample.
  logic       pv = 1'b0, pr = 1'b0, prst = 1'b1, pe = 1'b0, pl = 1'b0;
  logic [7:0] pd = '0;
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      got_q.push_back(m_data);
      eol_q.push_back(m_eol);
      last_q.push_back(m_last);
    end
    if (sent) sent_cnt++;
    if (overrun) ovr_cnt++;
    if (pv && !pr && !prst) begin
      check("hold_valid", m_valid, 1);
      check("hold_data", m_data, pd);
      check("hold_eol", m_eol, pe);
      check("hold_last", m_last, pl);
    end
    pv = m_valid; pr = m_ready; prst = rst; pd = m_data; pe = m_eol; pl = m_last;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, o0, k;

    rst = 1'b1; frame_done = 1'b0; m_ready = 1'b0;
    set_image(10, 10);
    step(); step();
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_busy", busy, 0);
    check("rst_sent", sent, 0);
    check("rst_ovr", overrun, 0);
    rst = 1'b0;
    step(); step();

    // Basic frame, sink always ready
    m_ready = 1'b1; frame_done = 1'b1;
    step();
    check("t1_valid", m_valid, 1);
    check("t1_busy", busy, 1);
    for (int i = 0; i < H * W; i++) begin
      check($sformatf("t1_data%0d", i), m_data, 10 * (i + 1));
      check($sformatf("t1_eol%0d", i), m_eol, (i % W) == W - 1);
      check($sformatf("t1_last%0d", i), m_last, i == H * W - 1);
      step();
    end
    check("t1_sent", sent, 1);
    check("t1_valid_end", m_valid, 0);
    check("t1_busy_end", busy, 0);
    step();
    check("t1_sent_one", sent, 0);
    frame_done = 1'b0;
    step();

    // Backpressure 1,0,0 repeating
    got_q.delete(); eol_q.delete(); last_q.delete();
    s0 = sent_cnt;
    m_ready = 1'b0; frame_done = 1'b1;
    step();
    frame_done = 1'b0;
    k = 0;
    while (!sent && k < 60) begin
      m_ready = (k % 3 == 0);
      step();
      k++;
    end
    check("t2_timeout", sent, 1);
    m_ready = 1'b1;
    step();
    check("t2_len", got_q.size(), 9);
    check_frame("t2", 10, 0);
    check("t2_sent_cnt", sent_cnt - s0, 1);

    // New edge mid-stream is dropped
    got_q.delete(); eol_q.delete(); last_q.delete();
    s0 = sent_cnt; o0 = ovr_cnt;
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
    step(); step(); step();
    check("t3_px3_before", m_data, 40);
    set_image(200, 3);
    frame_done = 1'b1;
    step();
    check("t3_ovr", overrun, 1);
    step();
    check("t3_ovr_one", overrun, 0);
    frame_done = 1'b0;
    wait_idle("t3");
    check("t3_len", got_q.size(), 9);
    check_frame("t3", 10, 0);
    check("t3_ovr_cnt", ovr_cnt - o0, 1);
    check("t3_sent_cnt", sent_cnt - s0, 1);

    // Back-to-back: second edge on the final handshake
    got_q.delete(); eol_q.delete(); last_q.delete();
    s0 = sent_cnt; o0 = ovr_cnt;
    set_image(10, 10);
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
    for (int i = 0; i < H * W - 1; i++) step();
    check("t4_at_last", m_last, 1);
    set_image(100, 10);
    frame_done = 1'b1;
    step();
    check("t4_sent", sent, 1);
    check("t4_valid", m_valid, 1);
    check("t4_data", m_data, 100);
    frame_done = 1'b0;
    wait_idle("t4");
    check("t4_len", got_q.size(), 18);
    check_frame("t4a", 10, 0);
    check_frame("t4b", 100, 9);
    check("t4_sent_cnt", sent_cnt - s0, 2);
    check("t4_ovr_cnt", ovr_cnt - o0, 0);

    // Reset after five handshakes
    set_image(10, 10);
    s0 = sent_cnt;
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("t5_px5", m_data, 60);
    rst = 1'b1;
    step();
    check("t5_valid", m_valid, 0);
    check("t5_data", m_data, 0);
    check("t5_eol", m_eol, 0);
    check("t5_last", m_last, 0);
    check("t5_busy", busy, 0);
    check("t5_sent", sent, 0);
    check("t5_ovr", overrun, 0);
    rst = 1'b0;
    step(); step();
    check("t5_no_sent", sent_cnt - s0, 0);
    got_q.delete(); eol_q.delete(); last_q.delete();
    frame_done = 1'b1;
    step();
    check("t5_restart_valid", m_valid, 1);
    check("t5_restart_data", m_data, 10);
    frame_done = 1'b0;
    wait_idle("t5");
    check("t5_len", got_q.size(), 9);
    check_frame("t5", 10, 0);

    // frame_done held high, image changes after capture
    got_q.delete(); eol_q.delete(); last_q.delete();
    s0 = sent_cnt;
    frame_done = 1'b1;
    step();
    set_image(200, 3);
    for (int i = 0; i < 49; i++) step();
    check("t6_busy", busy, 0);
    check("t6_len", got_q.size(), 9);
    check_frame("t6", 10, 0);
    check("t6_sent_cnt", sent_cnt - s0, 1);
    frame_done = 1'b0;
    step();

    // frame_done already high at reset release is not an edge
    set_image(10, 10);
    frame_done = 1'b1;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step(); step(); step();
    check("t7_no_edge", busy, 0);
    frame_done = 1'b0;
    step();
    frame_done = 1'b1;
    step();
    check("t7_edge", busy, 1);
    check("t7_data", m_data, 10);
    frame_done = 1'b0;
    wait_idle("t7");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
